// File: rtl/iq_capture_averager_if.sv
// Handshake and data bundle between the I/Q capture averager and its neighbours:
// acquisition control and filtered sample input, plus the readout stream toward host memory.
interface iq_capture_averager_if #(
  parameter int LANES    = 4,
  parameter int SAMPLE_W = 16,
  parameter int ACC_W    = 24
);
  logic                      start;
  logic [7:0]                num_scans;
  logic                      capture_gate;
  logic                      data_valid;
  logic [LANES*SAMPLE_W-1:0] data_in_i;
  logic [LANES*SAMPLE_W-1:0] data_in_q;
  logic                      rd_valid;
  logic                      rd_ready;
  logic [LANES*ACC_W-1:0]    rd_data_i;
  logic [LANES*ACC_W-1:0]    rd_data_q;
  logic                      rd_last;
  logic                      busy;
  logic                      done;
  logic                      overflow;
  logic                      len_mismatch;

  modport master (
    output start, num_scans, capture_gate, data_valid, data_in_i, data_in_q, rd_ready,
    input  rd_valid, rd_data_i, rd_data_q, rd_last, busy, done, overflow, len_mismatch
  );

  modport slave (
    input  start, num_scans, capture_gate, data_valid, data_in_i, data_in_q, rd_ready,
    output rd_valid, rd_data_i, rd_data_q, rd_last, busy, done, overflow, len_mismatch
  );
endinterface

// File: rtl/iq_capture_averager.sv
// Coherent multi-scan I/Q averager: read-modify-write accumulation into block RAM, then valid/ready readout.
// Define IQ_CAPTURE_DECIM2_EN to store only the even-numbered valid words of each scan.
module iq_capture_averager #(
  parameter int LANES    = 4,
  parameter int SAMPLE_W = 16,
  parameter int ACC_W    = 24,
  parameter int DEPTH    = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  iq_capture_averager_if.slave bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;
  localparam int DW     = LANES * ACC_W;
  localparam int SW     = LANES * SAMPLE_W;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  typedef enum logic [2:0] {IDLE, WAIT_GATE, CAPTURE, WAIT_LOW, READOUT} state_t;

  state_t            state_q, state_d;
  logic [7:0]        numScans_q, numScans_d;
  logic [7:0]        scanCnt_q, scanCnt_d;
  logic [CNT_W-1:0]  addr_q, addr_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  rdAddr_q, rdAddr_d;
  logic              overflow_q, overflow_d;
  logic              lenMismatch_q, lenMismatch_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              primed_q, primed_d;
  logic              rdValid_q, rdValid_d;
  logic              rdLast_q, rdLast_d;
  logic              wrEn_q, wrEn_d;
  logic              wrScan0_q, wrScan0_d;
  logic [ADDR_W-1:0] wrAddr_q, wrAddr_d;
  logic [SW-1:0]     sampleI_q, sampleI_d, sampleQ_q, sampleQ_d;
  logic              gate_q;
  logic              wordSel, store, fetch, ramRdEn;
  logic [ADDR_W-1:0] ramRdAddr;
  logic [DW-1:0]     memRdI_q, memRdQ_q, wrDataI, wrDataQ;
  logic [DW-1:0]     memI [DEPTH];
  logic [DW-1:0]     memQ [DEPTH];

`ifdef IQ_CAPTURE_DECIM2_EN
  logic phase_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  phase_q <= 1'b0;
    else if (state_q == WAIT_GATE)               phase_q <= 1'b0;
    else if (state_q == CAPTURE && bus.data_valid) phase_q <= ~phase_q;
  end
  assign wordSel = bus.data_valid && !phase_q;
`else
  assign wordSel = bus.data_valid;
`endif

  // Scan 0 overwrites whatever the RAM held; later scans add onto the value read one cycle earlier.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign wrDataI[l*ACC_W +: ACC_W] = (wrScan0_q ? {ACC_W{1'b0}} : memRdI_q[l*ACC_W +: ACC_W]) +
        {{(ACC_W-SAMPLE_W){sampleI_q[l*SAMPLE_W+SAMPLE_W-1]}}, sampleI_q[l*SAMPLE_W +: SAMPLE_W]};
    assign wrDataQ[l*ACC_W +: ACC_W] = (wrScan0_q ? {ACC_W{1'b0}} : memRdQ_q[l*ACC_W +: ACC_W]) +
        {{(ACC_W-SAMPLE_W){sampleQ_q[l*SAMPLE_W+SAMPLE_W-1]}}, sampleQ_q[l*SAMPLE_W +: SAMPLE_W]};
  end

  always_ff @(posedge clk) begin
    if (wrEn_q) begin
      memI[wrAddr_q] <= wrDataI;
      memQ[wrAddr_q] <= wrDataQ;
    end
    if (ramRdEn) begin
      memRdI_q <= memI[ramRdAddr];
      memRdQ_q <= memQ[ramRdAddr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      numScans_q    <= '0;
      scanCnt_q     <= '0;
      addr_q        <= '0;
      len_q         <= '0;
      rdAddr_q      <= '0;
      overflow_q    <= 1'b0;
      lenMismatch_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      primed_q      <= 1'b0;
      rdValid_q     <= 1'b0;
      rdLast_q      <= 1'b0;
      wrEn_q        <= 1'b0;
      wrScan0_q     <= 1'b0;
      wrAddr_q      <= '0;
      sampleI_q     <= '0;
      sampleQ_q     <= '0;
      gate_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      numScans_q    <= numScans_d;
      scanCnt_q     <= scanCnt_d;
      addr_q        <= addr_d;
      len_q         <= len_d;
      rdAddr_q      <= rdAddr_d;
      overflow_q    <= overflow_d;
      lenMismatch_q <= lenMismatch_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      primed_q      <= primed_d;
      rdValid_q     <= rdValid_d;
      rdLast_q      <= rdLast_d;
      wrEn_q        <= wrEn_d;
      wrScan0_q     <= wrScan0_d;
      wrAddr_q      <= wrAddr_d;
      sampleI_q     <= sampleI_d;
      sampleQ_q     <= sampleQ_d;
      gate_q        <= bus.capture_gate;
    end
  end

  always_comb begin
    state_d       = state_q;
    numScans_d    = numScans_q;
    scanCnt_d     = scanCnt_q;
    addr_d        = addr_q;
    len_d         = len_q;
    rdAddr_d      = rdAddr_q;
    overflow_d    = overflow_q;
    lenMismatch_d = lenMismatch_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    primed_d      = 1'b0;
    rdValid_d     = rdValid_q;
    rdLast_d      = rdLast_q;
    wrEn_d        = 1'b0;
    wrScan0_d     = (scanCnt_q == 8'd0);
    wrAddr_d      = addr_q[ADDR_W-1:0];
    sampleI_d     = bus.data_in_i;
    sampleQ_d     = bus.data_in_q;
    store         = 1'b0;
    fetch         = 1'b0;
    ramRdEn       = 1'b0;
    ramRdAddr     = addr_q[ADDR_W-1:0];

    case (state_q)
      IDLE: begin
        if (bus.start && bus.num_scans != 8'd0) begin
          state_d       = WAIT_GATE;
          numScans_d    = bus.num_scans;
          scanCnt_d     = 8'd0;
          rdAddr_d      = '0;
          overflow_d    = 1'b0;
          lenMismatch_d = 1'b0;
          busy_d        = 1'b1;
        end
      end
      WAIT_GATE: begin
        if (bus.capture_gate && !gate_q) begin
          state_d = CAPTURE;
          addr_d  = '0;
        end
      end
      CAPTURE: begin
        if (wordSel) begin
          if (addr_q == DEPTH_C)                          overflow_d    = 1'b1;
          else if (scanCnt_q != 8'd0 && addr_q >= len_q)  lenMismatch_d = 1'b1;
          else                                            store         = 1'b1;
        end
        if (store) begin
          addr_d  = addr_q + ONE_C;
          wrEn_d  = 1'b1;
          ramRdEn = 1'b1;
        end
        // The gate's falling-edge cycle still accepts a word, so the scan length is taken from addr_d.
        if (!bus.capture_gate) begin
          if (scanCnt_q == 8'd0)  len_d         = addr_d;
          else if (addr_d < len_q) lenMismatch_d = 1'b1;
          scanCnt_d = scanCnt_q + 8'd1;
          state_d   = (scanCnt_q + 8'd1 == numScans_q) ? READOUT : WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        if (!bus.capture_gate) state_d = WAIT_GATE;
      end
      READOUT: begin
        // primed_q delays the first fetch one cycle so the final capture write has landed.
        primed_d = 1'b1;
        fetch    = primed_q && (rdAddr_q < len_q) && (!rdValid_q || bus.rd_ready);
        if (fetch) begin
          ramRdEn   = 1'b1;
          ramRdAddr = rdAddr_q[ADDR_W-1:0];
          rdAddr_d  = rdAddr_q + ONE_C;
          rdValid_d = 1'b1;
          rdLast_d  = (rdAddr_q == len_q - ONE_C);
        end else if (bus.rd_ready) begin
          rdValid_d = 1'b0;
        end
        if ((len_q == '0) || (rdValid_q && bus.rd_ready && rdLast_q)) begin
          state_d = IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.rd_valid     = rdValid_q;
  assign bus.rd_data_i    = rdValid_q ? memRdI_q : '0;
  assign bus.rd_data_q    = rdValid_q ? memRdQ_q : '0;
  assign bus.rd_last      = rdValid_q && rdLast_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.overflow     = overflow_q;
  assign bus.len_mismatch = lenMismatch_q;
endmodule

// File: tb/tb_iq_capture_averager.sv
// Scoreboard bench for iq_capture_averager: a behavioural accumulation model queues expected readout words,
// which are popped and compared as the DUT hands them over. Honours IQ_CAPTURE_DECIM2_EN when defined.
module tb_iq_capture_averager;
  localparam int LANES    = 4;
  localparam int SAMPLE_W = 16;
  localparam int ACC_W    = 24;
  localparam int DEPTH    = 1024;
  localparam int DW       = LANES * ACC_W;
  localparam int SW       = LANES * SAMPLE_W;

  typedef struct packed {
    logic [DW-1:0] i;
    logic [DW-1:0] q;
    logic          last;
  } rdWord_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  iq_capture_averager_if #(.LANES(LANES), .SAMPLE_W(SAMPLE_W), .ACC_W(ACC_W)) bus();

  iq_capture_averager #(.LANES(LANES), .SAMPLE_W(SAMPLE_W), .ACC_W(ACC_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  rdWord_t       expQueue[$];
  int            checkCount = 0;
  int            passCount  = 0;
  logic [DW-1:0] refI [DEPTH];
  logic [DW-1:0] refQ [DEPTH];
  int            modelAddr, modelLen, modelScan;
  bit            modelPhase, expOvf, expMism;
  int            scanLen [8];
  bit            checkConst = 0;
  int            doneCount;

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
  endtask

  function automatic logic [ACC_W-1:0] sext(input logic [SAMPLE_W-1:0] s);
    logic signed [SAMPLE_W-1:0] ss;
    logic signed [ACC_W-1:0]    e;
    ss = s;
    e  = ss;
    return e;
  endfunction

  // Behavioural view of one valid input word arriving during a scan
  task automatic modelWord(input logic [SW-1:0] wI, input logic [SW-1:0] wQ);
    bit storeIt = 1'b1;
    logic [ACC_W-1:0] baseI, baseQ;
`ifdef IQ_CAPTURE_DECIM2_EN
    storeIt    = !modelPhase;
    modelPhase = !modelPhase;
`endif
    if (storeIt) begin
      if (modelAddr == DEPTH) expOvf = 1'b1;
      else if (modelScan > 0 && modelAddr >= modelLen) expMism = 1'b1;
      else begin
        for (int l = 0; l < LANES; l++) begin
          baseI = (modelScan == 0) ? '0 : refI[modelAddr][l*ACC_W +: ACC_W];
          baseQ = (modelScan == 0) ? '0 : refQ[modelAddr][l*ACC_W +: ACC_W];
          refI[modelAddr][l*ACC_W +: ACC_W] = baseI + sext(wI[l*SAMPLE_W +: SAMPLE_W]);
          refQ[modelAddr][l*ACC_W +: ACC_W] = baseQ + sext(wQ[l*SAMPLE_W +: SAMPLE_W]);
        end
        modelAddr++;
      end
    end
  endtask

  // kind 0: lanes = word index (Q negated); kind 1: -100 everywhere; kind 2: random with idle gaps
  task automatic applyStimulus(input int numScans, input int kind);
    logic [SW-1:0]       wI, wQ;
    logic [SAMPLE_W-1:0] v;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.num_scans = numScans[7:0];
    @(negedge clk);
    bus.start = 1'b0;
    checkOutput("busyRise", bus.busy, 1);
    modelScan = 0;
    expOvf    = 1'b0;
    expMism   = 1'b0;
    for (int s = 0; s < numScans; s++) begin
      repeat (2) @(negedge clk);
      bus.capture_gate = 1'b1;
      modelAddr  = 0;
      modelPhase = 1'b0;
      for (int k = 0; k < scanLen[s]; k++) begin
        @(negedge clk);
        if (kind == 2) begin
          while ($urandom_range(0, 3) == 0) begin
            bus.data_valid = 1'b0;
            @(negedge clk);
          end
        end
        for (int l = 0; l < LANES; l++) begin
          case (kind)
            0:       v = k[SAMPLE_W-1:0];
            1:       v = 16'hFF9C;
            default: v = $urandom_range(0, 65535);
          endcase
          wI[l*SAMPLE_W +: SAMPLE_W] = v;
          wQ[l*SAMPLE_W +: SAMPLE_W] = (kind == 2) ? 16'($urandom_range(0, 65535)) : -v;
        end
        bus.data_valid = 1'b1;
        bus.data_in_i  = wI;
        bus.data_in_q  = wQ;
        if (k == scanLen[s] - 1) bus.capture_gate = 1'b0;
        modelWord(wI, wQ);
      end
      if (scanLen[s] == 0) begin
        @(negedge clk);
        bus.capture_gate = 1'b0;
      end
      if (modelScan == 0) modelLen = modelAddr;
      else if (modelAddr < modelLen) expMism = 1'b1;
      modelScan++;
      if (s != numScans - 1) begin
        @(negedge clk);
        bus.data_valid = 1'b0;
      end
    end
    for (int a = 0; a < modelLen; a++) expQueue.push_back('{i: refI[a], q: refQ[a], last: (a == modelLen - 1)});
  endtask

  // mode 0: ready high; mode 1: ready toggles each cycle; mode 2: random ready
  task automatic collectReadout(input int mode, input int budget);
    int            cycles = 0;
    int            lastHs = 0;
    bit            hadHs = 0, doneSeen = 0, holdPending = 0, toggle = 0, ready;
    logic [DW-1:0] holdI, holdQ;
    rdWord_t       e;
    while (!doneSeen && cycles < budget) begin
      @(negedge clk);
      cycles++;
      bus.data_valid = 1'b0;
      if (bus.done) begin
        doneSeen = 1'b1;
        checkOutput("busyFall", bus.busy, 0);
        if (hadHs) checkOutput("doneTiming", cycles, lastHs + 1);
      end else begin
        case (mode)
          0:       ready = 1'b1;
          1:       begin toggle = !toggle; ready = toggle; end
          default: ready = 1'($urandom_range(0, 1));
        endcase
        bus.rd_ready = ready;
        if (holdPending && !bus.rd_valid) begin
          checkOutput("stallValid", 0, 1);
          holdPending = 1'b0;
        end
        if (bus.rd_valid) begin
          if (holdPending) begin
            checkOutput("stallHoldI", bus.rd_data_i, holdI);
            checkOutput("stallHoldQ", bus.rd_data_q, holdQ);
          end
          if (ready) begin
            holdPending = 1'b0;
            hadHs  = 1'b1;
            lastHs = cycles;
            if (expQueue.size() == 0) checkOutput("extraWord", 1, 0);
            else begin
              e = expQueue.pop_front();
              checkOutput("rdDataI", bus.rd_data_i, e.i);
              checkOutput("rdDataQ", bus.rd_data_q, e.q);
              checkOutput("rdLast", bus.rd_last, e.last);
              if (checkConst) checkOutput("sumMinus300", bus.rd_data_i[ACC_W-1:0], 24'hFFFED4);
            end
          end else begin
            holdPending = 1'b1;
            holdI = bus.rd_data_i;
            holdQ = bus.rd_data_q;
          end
        end
      end
    end
    bus.rd_ready = 1'b0;
    checkOutput("doneSeen", doneSeen, 1);
    checkOutput("wordsLeft", expQueue.size(), 0);
    expQueue.delete();
    checkOutput("overflow", bus.overflow, expOvf);
    checkOutput("lenMismatch", bus.len_mismatch, expMism);
    @(negedge clk);
    checkOutput("donePulse", bus.done, 0);
  endtask

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.start        = 1'b0;
    bus.num_scans    = 8'd0;
    bus.capture_gate = 1'b0;
    bus.data_valid   = 1'b0;
    bus.data_in_i    = '0;
    bus.data_in_q    = '0;
    bus.rd_ready     = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("resetBusy", bus.busy, 0);
    checkOutput("resetDone", bus.done, 0);
    checkOutput("resetRdValid", bus.rd_valid, 0);
    checkOutput("resetRdLast", bus.rd_last, 0);
    checkOutput("resetOverflow", bus.overflow, 0);
    checkOutput("resetLenMismatch", bus.len_mismatch, 0);
    rst_n = 1'b1;

    $display("[TB] start with num_scans=0 is ignored");
    @(negedge clk);
    bus.start = 1'b1;
    bus.num_scans = 8'd0;
    @(negedge clk);
    bus.start = 1'b0;
    checkOutput("zeroScansBusy", bus.busy, 0);

    $display("[TB] single scan of 8 index words");
    scanLen[0] = 8;
    applyStimulus(1, 0);
    collectReadout(0, 100);

    $display("[TB] three scans of -100, toggling ready");
    checkConst = 1'b1;
    scanLen[0] = 16; scanLen[1] = 16; scanLen[2] = 16;
    applyStimulus(3, 1);
    collectReadout(1, 200);
    checkConst = 1'b0;

    $display("[TB] short second scan (12 then 10)");
    scanLen[0] = 12; scanLen[1] = 10;
    applyStimulus(2, 2);
    collectReadout(2, 200);

    $display("[TB] long second scan (8 then 11)");
    scanLen[0] = 8; scanLen[1] = 11;
    applyStimulus(2, 2);
    collectReadout(0, 100);

    $display("[TB] 1030 words in one scan");
    scanLen[0] = 1030;
    applyStimulus(1, 2);
    collectReadout(0, 3000);

    $display("[TB] four random scans of 20 words, random ready");
    for (int s = 0; s < 4; s++) scanLen[s] = 20;
    applyStimulus(4, 2);
    collectReadout(2, 300);

    $display("[TB] empty scan");
    scanLen[0] = 0;
    applyStimulus(1, 2);
    collectReadout(0, 20);

    $display("[TB] reset mid-capture");
    @(negedge clk);
    bus.start = 1'b1;
    bus.num_scans = 8'd2;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    bus.capture_gate = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      bus.data_valid = 1'b1;
      bus.data_in_i  = {LANES{16'(k)}};
      bus.data_in_q  = {LANES{16'(k)}};
    end
    @(negedge clk);
    rst_n = 1'b0;
    bus.data_valid   = 1'b0;
    bus.capture_gate = 1'b0;
    bus.rd_ready     = 1'b1;
    @(negedge clk);
    checkOutput("abortBusy", bus.busy, 0);
    checkOutput("abortRdValid", bus.rd_valid, 0);
    rst_n = 1'b1;
    doneCount = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done) doneCount++;
    end
    bus.rd_ready = 1'b0;
    checkOutput("abortNoDone", doneCount, 0);
    checkOutput("abortStaysIdle", bus.busy, 0);

    $display("[TB] recovery after abort");
    scanLen[0] = 5;
    applyStimulus(1, 2);
    collectReadout(0, 50);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule

// File: doc/iq_capture_averager.md
# iq_capture_averager

Downstream stage of the NMR signal-processing datapath: consumes the filtered 4-lane I/Q baseband words from the signal-analysis stage while the ADC window is open, and coherently accumulates a programmed number of scans into on-chip block RAM. Once the last scan completes, it streams the summed record out over a valid/ready interface for transfer to the host memory bank. Accumulation is read-modify-write, pipelined to accept one input word per clock.

## Interface
- LANES, 4, samples per input word (200 MS/s lanes)
- SAMPLE_W, 16, signed input sample width
- ACC_W, 24, signed accumulator width per lane
- DEPTH, 1024, words per scan record (address width = clog2(DEPTH))
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle pulse that begins an acquisition
- num_scans  in  8  scans to accumulate, latched on start; 0 is invalid
- capture_gate  in  1  ADC window (driven by ADC enable); high = scan in progress
- data_valid  in  1  input word qualifier (filter valid)
- data_in_i, data_in_q  in  LANES*SAMPLE_W  signed I/Q, lane 0 in LSBs
- rd_valid  out  1  readout word available
- rd_ready  in  1  consumer accepts word
- rd_data_i, rd_data_q  out  LANES*ACC_W  accumulated sums, lane 0 in LSBs
- rd_last  out  1  marks final readout word
- busy  out  1  high from accepted start until readout completes
- done  out  1  one-cycle pulse after final readout handshake
- overflow  out  1  sticky: a scan exceeded DEPTH words
- len_mismatch  out  1  sticky: a scan length differed from scan 0

## Operation
- States: IDLE, WAIT_GATE, CAPTURE, WAIT_LOW, READOUT.
- IDLE: start with num_scans != 0 -> WAIT_GATE; latches num_scans, clears scan counter, overflow, len_mismatch; busy rises. start with num_scans = 0, or start in any other state, is ignored.
- WAIT_GATE: capture_gate rising edge -> CAPTURE, write address = 0.
- CAPTURE: each data_valid word stored at current address, address increments. Scan 0 writes sample sign-extended to ACC_W (overwrites stale RAM). Scans >=1 write RAM[addr] + sign-extended sample per lane.
- Words arriving at address = DEPTH are dropped and set overflow. On scans >=1, words beyond scan-0 length are dropped and set len_mismatch; scans shorter than scan 0 also set len_mismatch (unwritten tail keeps prior sums).
- capture_gate falling -> scan ends; scan 0 records its length L (words accepted). If scan counter + 1 = num_scans -> READOUT, else -> WAIT_LOW then WAIT_GATE.
- READOUT: streams addresses 0..L-1; rd_last with address L-1. Word transfers when rd_valid && rd_ready; rd_valid/rd_data held stable while rd_ready low. After last transfer: done pulses, busy falls, -> IDLE. L = 0 -> no words, done pulses, IDLE.
- data_valid outside CAPTURE is ignored. Arithmetic is two's complement, no saturation; ACC_W=24 holds 255 full-scale 16-bit scans exactly.

## Timing
- Reset: all outputs 0, state IDLE; RAM contents undefined (scan 0 overwrites). rst_n low mid-operation aborts immediately, with no done pulse.
- RMW pipeline: read at cycle n, write at n+1; back-to-back valid words are legal (consecutive addresses, no hazard). A valid word on the same cycle as the gate falling edge is accepted.
- busy rises the cycle after start.
- First rd_valid 2 cycles after entering READOUT (RAM prefetch). Zero-bubble throughput with rd_ready held high.
- done asserts the cycle after the final handshake.

## Configuration
- IQ_CAPTURE_DECIM2_EN defined: only even-numbered valid words of each scan (0th, 2nd, ...) are stored, so L counts stored words and the DEPTH limit applies to stored words. Undefined: every valid word is stored.

## Test plan
- num_scans=1, gate open for 8 valid words of lane values k (word k) -> 8 readout words equal to sign-extended k, rd_last on word 7, done one cycle after.
- num_scans=3, identical 16-word scans of -100 on all lanes -> every readout lane = -300 (0xFFFED4 at 24 bits).
- Scan 1 of 10 words after a 12-word scan 0 with num_scans=2 -> len_mismatch=1, words 10-11 hold scan-0 values, readout length 12.
- 1030 valid words in one scan -> overflow=1, readout of 1024 words.
- rd_ready toggling 1/0 every cycle -> data held while stalled, no duplicates or drops; rst_n pulsed low mid-CAPTURE -> busy=0 and rd_valid=0, done never asserted.
- With IQ_CAPTURE_DECIM2_EN, 8 words 0..7 -> readout 0,2,4,6.
